// File: rtl/regfile_sb.sv
// regfile_sb: parametrised register file with two combinational read ports,
// one synchronous write port and a per-register busy scoreboard.
// Optional feature macro: REGFILE_BYPASS_EN enables same-cycle forwarding of
// the write port (data and busy) onto the read ports.
// ZERO_REG=1 hard-wires register 0 to zero and keeps it never busy.
module regfile_sb #(
    parameter int WIDTH    = 16,
    parameter int DEPTH    = 8,
    parameter int AW       = $clog2(DEPTH),
    parameter int ZERO_REG = 0
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [AW-1:0]    raddr_a,
    input  logic [AW-1:0]    raddr_b,
    output logic [WIDTH-1:0] rdata_a,
    output logic [WIDTH-1:0] rdata_b,
    output logic             busy_a,
    output logic             busy_b,
    input  logic             we,
    input  logic [AW-1:0]    waddr,
    input  logic [WIDTH-1:0] wdata,
    input  logic             issue,
    input  logic [AW-1:0]    issue_addr,
    output logic [AW:0]      busy_cnt
);

    logic [WIDTH-1:0] regs_q [DEPTH];
    logic [DEPTH-1:0] busy_q;
    logic [DEPTH-1:0] busy_d;
    logic [AW:0]      busy_cnt_q;
    logic [AW:0]      busy_cnt_d;

    logic             we_eff;
    logic             issue_eff;
    logic             cnt_inc;
    logic             cnt_dec;

    // Writes and issues aimed at a hard-wired zero register are dropped here,
    // so nothing downstream needs to special-case register 0.
    assign we_eff    = we    && !((ZERO_REG != 0) && (waddr == '0));
    assign issue_eff = issue && !((ZERO_REG != 0) && (issue_addr == '0));

    // Next busy vector and count delta; issue is applied after write so a
    // same-address issue+write leaves the register busy (new producer wins).
    always_comb begin
        // NOTE: every signal assigned here gets a default first, otherwise the
        // paths where no branch assigns it would infer a latch.
        busy_d  = busy_q;
        cnt_inc = 1'b0;
        cnt_dec = 1'b0;
        if (we_eff) begin
            busy_d[waddr] = 1'b0;
        end
        if (issue_eff) begin
            busy_d[issue_addr] = 1'b1;
        end
        cnt_inc = issue_eff && !busy_q[issue_addr];
        cnt_dec = we_eff && busy_q[waddr] &&
                  !(issue_eff && (issue_addr == waddr));
        busy_cnt_d = busy_cnt_q + (AW+1)'(cnt_inc) - (AW+1)'(cnt_dec);
    end

    // Register array: reset preloads each register with its own index.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            // NOTE: the array is reset explicitly because its reset contents
            // (regs[i] = i) are architecturally visible, not just a
            // convenience; this keeps it in flops rather than a RAM macro.
            for (int i = 0; i < DEPTH; i++) begin
                regs_q[i] <= WIDTH'(i);
            end
        end else if (we_eff) begin
            // NOTE: state is always updated with non-blocking assignments so
            // every reader in this edge sees the pre-edge value.
            regs_q[waddr] <= wdata;
        end
    end

    // Busy scoreboard and its registered population count.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            busy_q     <= '0;
            busy_cnt_q <= '0;
        end else begin
            busy_q     <= busy_d;
            busy_cnt_q <= busy_cnt_d;
        end
    end

    assign busy_cnt = busy_cnt_q;

    // Read port A: registered state, optional forwarding, zero-register force.
    always_comb begin
        rdata_a = regs_q[raddr_a];
        busy_a  = busy_q[raddr_a];
`ifdef REGFILE_BYPASS_EN
        // Forwarding is gated by rst_n so reads during reset show reset state.
        if (rst_n && we_eff && (waddr == raddr_a)) begin
            rdata_a = wdata;
            busy_a  = issue_eff && (issue_addr == raddr_a);
        end
`else
`endif
        if ((ZERO_REG != 0) && (raddr_a == '0)) begin
            rdata_a = '0;
            busy_a  = 1'b0;
        end
    end

    // Read port B: identical structure to port A.
    always_comb begin
        rdata_b = regs_q[raddr_b];
        busy_b  = busy_q[raddr_b];
`ifdef REGFILE_BYPASS_EN
        if (rst_n && we_eff && (waddr == raddr_b)) begin
            rdata_b = wdata;
            busy_b  = issue_eff && (issue_addr == raddr_b);
        end
`else
`endif
        if ((ZERO_REG != 0) && (raddr_b == '0)) begin
            rdata_b = '0;
            busy_b  = 1'b0;
        end
    end

endmodule

// File: tb/tb_regfile_sb.sv
// Scoreboard bench for regfile_sb. Three instances: default (16x8),
// ZERO_REG=1 (16x8) and wide (32x16). Stimulus pushes the expected read-port
// view for the current cycle; a monitor on the falling edge pops and compares.
module tb_regfile_sb;

`ifdef REGFILE_BYPASS_EN
    localparam bit BYP = 1'b1;
`else
    localparam bit BYP = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    // Default instance signals
    logic [2:0]  d_raddr_a, d_raddr_b, d_waddr, d_issue_addr;
    logic [15:0] d_rdata_a, d_rdata_b, d_wdata;
    logic        d_busy_a, d_busy_b, d_we, d_issue;
    logic [3:0]  d_busy_cnt;

    // Zero-register instance signals
    logic [2:0]  z_raddr_a, z_raddr_b, z_waddr, z_issue_addr;
    logic [15:0] z_rdata_a, z_rdata_b, z_wdata;
    logic        z_busy_a, z_busy_b, z_we, z_issue;
    logic [3:0]  z_busy_cnt;

    // Wide instance signals
    logic [3:0]  w_raddr_a, w_raddr_b, w_waddr, w_issue_addr;
    logic [31:0] w_rdata_a, w_rdata_b, w_wdata;
    logic        w_busy_a, w_busy_b, w_we, w_issue;
    logic [4:0]  w_busy_cnt;

    regfile_sb dut (
        .clk(clk), .rst_n(rst_n),
        .raddr_a(d_raddr_a), .raddr_b(d_raddr_b),
        .rdata_a(d_rdata_a), .rdata_b(d_rdata_b),
        .busy_a(d_busy_a), .busy_b(d_busy_b),
        .we(d_we), .waddr(d_waddr), .wdata(d_wdata),
        .issue(d_issue), .issue_addr(d_issue_addr),
        .busy_cnt(d_busy_cnt)
    );

    regfile_sb #(.ZERO_REG(1)) dut_z (
        .clk(clk), .rst_n(rst_n),
        .raddr_a(z_raddr_a), .raddr_b(z_raddr_b),
        .rdata_a(z_rdata_a), .rdata_b(z_rdata_b),
        .busy_a(z_busy_a), .busy_b(z_busy_b),
        .we(z_we), .waddr(z_waddr), .wdata(z_wdata),
        .issue(z_issue), .issue_addr(z_issue_addr),
        .busy_cnt(z_busy_cnt)
    );

    regfile_sb #(.WIDTH(32), .DEPTH(16)) dut_w (
        .clk(clk), .rst_n(rst_n),
        .raddr_a(w_raddr_a), .raddr_b(w_raddr_b),
        .rdata_a(w_rdata_a), .rdata_b(w_rdata_b),
        .busy_a(w_busy_a), .busy_b(w_busy_b),
        .we(w_we), .waddr(w_waddr), .wdata(w_wdata),
        .issue(w_issue), .issue_addr(w_issue_addr),
        .busy_cnt(w_busy_cnt)
    );

    typedef struct {
        int          unit;
        string       name;
        logic [31:0] ra;
        logic [31:0] rb;
        logic        ba;
        logic        bb;
        logic [31:0] cnt;
    } exp_t;

    exp_t sb_q[$];
    int   n_checks = 0;
    int   n_fail   = 0;

    task automatic check(input string name, input logic [31:0] act,
                         input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    task automatic expect_out(input int unit, input string name,
                              input logic [31:0] ra, input logic [31:0] rb,
                              input logic ba, input logic bb,
                              input logic [31:0] cnt);
        exp_t e;
        e.unit = unit; e.name = name;
        e.ra = ra; e.rb = rb; e.ba = ba; e.bb = bb; e.cnt = cnt;
        sb_q.push_back(e);
    endtask

    // Monitor: compares every pending expectation against the live outputs.
    exp_t        mon_e;
    logic [31:0] a_ra, a_rb, a_cnt;
    logic        a_ba, a_bb;
    always @(negedge clk) begin
        while (sb_q.size() > 0) begin
            mon_e = sb_q.pop_front();
            case (mon_e.unit)
                0: begin
                    a_ra = 32'(d_rdata_a); a_rb = 32'(d_rdata_b);
                    a_ba = d_busy_a; a_bb = d_busy_b; a_cnt = 32'(d_busy_cnt);
                end
                1: begin
                    a_ra = 32'(z_rdata_a); a_rb = 32'(z_rdata_b);
                    a_ba = z_busy_a; a_bb = z_busy_b; a_cnt = 32'(z_busy_cnt);
                end
                default: begin
                    a_ra = w_rdata_a; a_rb = w_rdata_b;
                    a_ba = w_busy_a; a_bb = w_busy_b; a_cnt = 32'(w_busy_cnt);
                end
            endcase
            check({mon_e.name, ".rdata_a"}, a_ra, mon_e.ra);
            check({mon_e.name, ".rdata_b"}, a_rb, mon_e.rb);
            check({mon_e.name, ".busy_a"}, 32'(a_ba), 32'(mon_e.ba));
            check({mon_e.name, ".busy_b"}, 32'(a_bb), 32'(mon_e.bb));
            check({mon_e.name, ".busy_cnt"}, a_cnt, mon_e.cnt);
        end
    end

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        {d_raddr_a, d_raddr_b, d_waddr, d_issue_addr, d_wdata, d_we, d_issue} = '0;
        {z_raddr_a, z_raddr_b, z_waddr, z_issue_addr, z_wdata, z_we, z_issue} = '0;
        {w_raddr_a, w_raddr_b, w_waddr, w_issue_addr, w_wdata, w_we, w_issue} = '0;
        rst_n = 1'b1;
        #1 rst_n = 1'b0;

        // During reset: preload values visible, a write attempt is ignored.
        next_cycle();
        d_raddr_a = 3'd2; d_raddr_b = 3'd7;
        d_we = 1'b1; d_waddr = 3'd2; d_wdata = 16'h7777;
        z_raddr_a = 3'd1; z_raddr_b = 3'd0;
        w_raddr_a = 4'd15; w_raddr_b = 4'd9;
        expect_out(0, "in_reset_d", 2, 7, 0, 0, 0);
        expect_out(1, "in_reset_z", 1, 0, 0, 0, 0);
        expect_out(2, "in_reset_w", 15, 9, 0, 0, 0);

        // Release; read 0..3 on A and 4 on B.
        next_cycle();
        rst_n = 1'b1; d_we = 1'b0;
        d_raddr_a = 3'd0; d_raddr_b = 3'd4;
        expect_out(0, "post_rst_r0", 0, 4, 0, 0, 0);
        for (int i = 1; i < 4; i++) begin
            next_cycle();
            d_raddr_a = 3'(i);
            expect_out(0, $sformatf("post_rst_r%0d", i), 32'(i), 4, 0, 0, 0);
        end

        // Issue r5, then write BEEF to r5.
        next_cycle();
        d_raddr_a = 3'd5; d_issue = 1'b1; d_issue_addr = 3'd5;
        expect_out(0, "issue5", 5, 4, 0, 0, 0);
        next_cycle();
        d_issue = 1'b0; d_we = 1'b1; d_waddr = 3'd5; d_wdata = 16'hBEEF;
        expect_out(0, "write5", BYP ? 32'hBEEF : 32'd5, 4, BYP ? 1'b0 : 1'b1, 0, 1);
        next_cycle();
        d_we = 1'b0;
        expect_out(0, "after_write5", 32'hBEEF, 4, 0, 0, 0);

        // Same-cycle issue and write to r3: data lands, busy stays set.
        next_cycle();
        d_raddr_a = 3'd3; d_issue = 1'b1; d_issue_addr = 3'd3;
        d_we = 1'b1; d_waddr = 3'd3; d_wdata = 16'h1234;
        expect_out(0, "iw3", BYP ? 32'h1234 : 32'd3, 4, BYP ? 1'b1 : 1'b0, 0, 0);
        // Re-issue busy r3: count must not move.
        next_cycle();
        d_we = 1'b0;
        expect_out(0, "reissue3", 32'h1234, 4, 1, 0, 1);
        // Write non-busy r6.
        next_cycle();
        d_issue = 1'b0; d_raddr_b = 3'd6;
        d_we = 1'b1; d_waddr = 3'd6; d_wdata = 16'h00AA;
        expect_out(0, "write6", 32'h1234, BYP ? 32'h00AA : 32'd6, 1, 0, 1);
        // Writeback r3 clears its busy bit.
        next_cycle();
        d_waddr = 3'd3; d_wdata = 16'h0033;
        expect_out(0, "wb3", BYP ? 32'h0033 : 32'h1234, 32'h00AA, BYP ? 1'b0 : 1'b1, 0, 1);

        // Issue r1, r2, r7 on consecutive cycles.
        next_cycle();
        d_we = 1'b0; d_issue = 1'b1; d_issue_addr = 3'd1;
        d_raddr_a = 3'd1; d_raddr_b = 3'd7;
        expect_out(0, "iss1", 1, 7, 0, 0, 0);
        next_cycle();
        d_issue_addr = 3'd2;
        expect_out(0, "iss2", 1, 7, 1, 0, 1);
        next_cycle();
        d_issue_addr = 3'd7;
        expect_out(0, "iss7", 1, 7, 1, 0, 2);
        next_cycle();
        d_issue = 1'b0;
        expect_out(0, "three_busy", 1, 7, 1, 1, 3);

        // Asynchronous reset mid-cycle: immediate return to reset view.
        next_cycle();
        #1 rst_n = 1'b0;
        d_raddr_b = 3'd5;
        expect_out(0, "async_rst", 1, 5, 0, 0, 0);
        next_cycle();
        rst_n = 1'b1;

        // Zero-register instance.
        next_cycle();
        z_raddr_a = 3'd0; z_raddr_b = 3'd4; z_issue = 1'b1; z_issue_addr = 3'd4;
        expect_out(1, "z_iss4", 0, 4, 0, 0, 0);
        next_cycle();
        z_issue_addr = 3'd0; z_we = 1'b1; z_waddr = 3'd0; z_wdata = 16'hFFFF;
        expect_out(1, "z_wr0", 0, 4, 0, 1, 1);
        next_cycle();
        z_issue = 1'b0; z_we = 1'b0;
        expect_out(1, "z_after0", 0, 4, 0, 1, 1);

        // Wide instance: top register.
        next_cycle();
        w_we = 1'b1; w_waddr = 4'd15; w_wdata = 32'hDEADBEEF;
        w_raddr_a = 4'd15; w_raddr_b = 4'd15;
        expect_out(2, "w_wr15", BYP ? 32'hDEADBEEF : 32'd15,
                   BYP ? 32'hDEADBEEF : 32'd15, 0, 0, 0);
        next_cycle();
        w_we = 1'b0;
        expect_out(2, "w_rd15", 32'hDEADBEEF, 32'hDEADBEEF, 0, 0, 0);

        next_cycle();
        next_cycle();
        check("scoreboard_drained", 32'(sb_q.size()), 0);
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
